mux_sel_arbiter: RTL and testbench

- Two-source stream arbiter that sits directly upstream of the 2:1 MUX datapath and generates its select line.
- Arbitrates two valid/ready sources with round-robin fairness and a bounded burst length.
- The `sel` output drives the MUX select (0 = source A, 1 = source B).
- The granted beat is forwarded through a one-deep output register.

---
 rtl/mux_pkg.sv | 17 +
 rtl/stream_reg.sv | 43 ++++
 rtl/mux_sel_arbiter.sv | 119 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types for the two-source MUX select arbiter.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic state_e grant_of(input logic src);
    return (src == SEL_B) ? GRANT_B : GRANT_A;
  endfunction

endpackage

// File: rtl/stream_reg.sv
// One-deep valid/ready register; accepts a beat whenever it is empty or being drained.
module stream_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin, burst-bounded arbiter for two streams; drives the 2:1 MUX select
// and forwards the granted beat through a one-deep output register.
//   state   | meaning
//   IDLE    | no grant; sel holds its last value
//   GRANT_A | source A owns the MUX (sel = 0)
//   GRANT_B | source B owns the MUX (sel = 1)
module mux_sel_arbiter
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             sel
);

  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_sel_q, last_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             stage_open;
  logic             x_valid, o_valid, xfer;
  logic [WIDTH-1:0] mux_data;

  // rst gating keeps a beat from being accepted in the same cycle it is flushed
  assign a_ready  = (state_q == GRANT_A) && stage_open && !rst;
  assign b_ready  = (state_q == GRANT_B) && stage_open && !rst;
  assign sel      = sel_q;
  assign x_valid  = (sel_q == SEL_B) ? b_valid : a_valid;
  assign o_valid  = (sel_q == SEL_B) ? a_valid : b_valid;
  assign xfer     = (a_valid && a_ready) || (b_valid && b_ready);
  assign mux_data = (sel_q == SEL_B) ? b_data : a_data;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_sel_d = last_sel_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (a_valid && b_valid) begin
          sel_d   = !last_sel_q;
          state_d = grant_of(!last_sel_q);
        end else if (a_valid) begin
          sel_d   = SEL_A;
          state_d = GRANT_A;
        end else if (b_valid) begin
          sel_d   = SEL_B;
          state_d = GRANT_B;
        end
      end
      GRANT_A, GRANT_B: begin
        if (xfer) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (o_valid) begin
              state_d    = grant_of(!sel_q);
              sel_d      = !sel_q;
              last_sel_d = sel_q;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (!x_valid) begin
          cnt_d      = '0;
          last_sel_d = sel_q;
          if (o_valid) begin
            state_d = grant_of(!sel_q);
            sel_d   = !sel_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= SEL_A;
      last_sel_q <= SEL_B;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_sel_q <= last_sel_d;
      cnt_q      <= cnt_d;
    end
  end

  stream_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (xfer),
    .in_data  (mux_data),
    .in_ready (stage_open),
    .out_valid(y_valid),
    .out_data (y_data),
    .out_ready(y_ready)
  );

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: queue-fed sources, scoreboard monitor on y.
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0, b_valid = 1'b0, y_ready = 1'b1;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       a_ready, b_ready, y_valid, sel;
  logic [7:0] y_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int phase = 0;
  bit b_seen = 1'b0;
  bit a_hs = 1'b0, b_hs = 1'b0;

  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  logic [7:0] exp_q[$];
  int         pop_cyc[$];

  mux_sel_arbiter #(.WIDTH(8), .BURST(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .a_valid(a_valid),
    .a_data (a_data),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_data (b_data),
    .b_ready(b_ready),
    .y_valid(y_valid),
    .y_data (y_data),
    .y_ready(y_ready),
    .sel    (sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // sources: present queue head; pop after a handshake seen before the edge
  always @(negedge clk) begin
    a_hs = a_valid && a_ready;
    b_hs = b_valid && b_ready;
  end

  always @(posedge clk) begin
    #1;
    if (a_hs && a_q.size() != 0) void'(a_q.pop_front());
    if (b_hs && b_q.size() != 0) void'(b_q.pop_front());
    a_valid = (a_q.size() != 0);
    a_data  = a_valid ? a_q[0] : 8'h00;
    b_valid = (b_q.size() != 0);
    b_data  = b_valid ? b_q[0] : 8'h00;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (y_valid && y_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got 0x%0h expected no beat", y_data);
      end else begin
        chk("y_data", {24'h0, y_data}, {24'h0, exp_q.pop_front()});
        pop_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) if (phase == 1 && b_ready) b_seen = 1'b1;

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    y_ready = 1'b1;
    a_q.delete();
    b_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    pop_cyc.delete();
  endtask

  task automatic drain(input string nm, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      nxt();
      k++;
    end
    chk({nm, "_left"}, exp_q.size(), 0);
  endtask

  function automatic int span(input int n);
    if (pop_cyc.size() < n) return -1;
    return pop_cyc[n-1] - pop_cyc[0];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset then A-only
    phase = 1;
    do_reset();
    #1;
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", y_data, 0);
    chk("rst_sel", sel, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    a_q = '{8'h10, 8'h11, 8'h12};
    exp_q = '{8'h10, 8'h11, 8'h12};
    nxt();
    chk("t1_bubble_a_ready", a_ready, 0);
    nxt();
    chk("t1_a_ready", a_ready, 1);
    chk("t1_sel", sel, 0);
    drain("t1", 20);
    chk("t1_span", span(3), 2);
    chk("t1_b_ready_seen", b_seen, 0);
    phase = 0;

    // both valid: A x4, B x4, A x4, B x4
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a_q.push_back(8'hA0 + 8'(i));
      b_q.push_back(8'hB0 + 8'(i));
    end
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 4; i++)
        exp_q.push_back(((g % 2) == 0 ? 8'hA0 : 8'hB0) + 8'((g / 2) * 4 + i));
    repeat (5) nxt();
    chk("t2_sel_n5", sel, 0);
    nxt();
    chk("t2_sel_n6", sel, 1);
    repeat (3) nxt();
    chk("t2_sel_n9", sel, 1);
    nxt();
    chk("t2_sel_n10", sel, 0);
    drain("t2", 40);
    chk("t2_span", span(16), 15);

    // B-only burst wrap
    do_reset();
    for (int i = 0; i < 10; i++) begin
      b_q.push_back(8'h40 + 8'(i));
      exp_q.push_back(8'h40 + 8'(i));
    end
    repeat (2) nxt();
    chk("t3_b_ready", b_ready, 1);
    chk("t3_a_ready", a_ready, 0);
    chk("t3_sel", sel, 1);
    drain("t3", 40);
    chk("t3_span", span(10), 9);
    nxt();
    chk("t3_idle_sel", sel, 1);
    chk("t3_idle_b_ready", b_ready, 0);

    // backpressure with B arriving mid-stall
    do_reset();
    for (int i = 0; i < 6; i++) a_q.push_back(8'h50 + 8'(i));
    exp_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61, 8'h54, 8'h55};
    repeat (4) @(posedge clk);
    #1;
    y_ready = 1'b0;
    nxt();
    chk("t4_stall_a_ready0", a_ready, 0);
    chk("t4_stall_y_valid0", y_valid, 1);
    chk("t4_stall_y_data0", y_data, 8'h51);
    b_q = '{8'h60, 8'h61};
    for (int s = 1; s < 3; s++) begin
      nxt();
      chk($sformatf("t4_stall_a_ready%0d", s), a_ready, 0);
      chk($sformatf("t4_stall_y_data%0d", s), y_data, 8'h51);
      chk($sformatf("t4_stall_sel%0d", s), sel, 0);
      chk($sformatf("t4_stall_b_ready%0d", s), b_ready, 0);
    end
    @(posedge clk);
    #1;
    y_ready = 1'b1;
    nxt();
    chk("t4_resume_a_ready", a_ready, 1);
    chk("t4_resume_sel", sel, 0);
    drain("t4", 40);

    // early release
    do_reset();
    a_q = '{8'h20, 8'h21};
    b_q = '{8'h30, 8'h31, 8'h32};
    exp_q = '{8'h20, 8'h21, 8'h30, 8'h31, 8'h32};
    repeat (4) nxt();
    chk("t5_a_hold_sel", sel, 0);
    chk("t5_a_hold_b_ready", b_ready, 0);
    nxt();
    chk("t5_switch_b_ready", b_ready, 1);
    chk("t5_switch_a_ready", a_ready, 0);
    chk("t5_switch_sel", sel, 1);
    drain("t5", 30);
    nxt();
    chk("t5_idle_sel", sel, 1);
    chk("t5_idle_b_ready", b_ready, 0);
    chk("t5_idle_a_ready", a_ready, 0);

    // reset mid-burst after A released (last_sel = A before the reset)
    do_reset();
    a_q = '{8'h6F};
    exp_q = '{8'h6F};
    repeat (4) nxt();
    b_q = '{8'h70, 8'h71, 8'h72};
    exp_q.push_back(8'h70);
    repeat (4) @(posedge clk);
    #1;
    y_ready = 1'b0;
    nxt();
    chk("t6_pre_y_valid", y_valid, 1);
    chk("t6_pre_y_data", y_data, 8'h71);
    chk("t6_pre_sel", sel, 1);
    rst = 1'b1;
    b_q.delete();
    nxt();
    chk("t6_rst_y_valid", y_valid, 0);
    chk("t6_rst_y_data", y_data, 0);
    chk("t6_rst_sel", sel, 0);
    chk("t6_rst_a_ready", a_ready, 0);
    chk("t6_rst_b_ready", b_ready, 0);
    rst = 1'b0;
    y_ready = 1'b1;
    a_q = '{8'h80};
    b_q = '{8'h90};
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h90);
    repeat (2) nxt();
    chk("t6_tie_a_ready", a_ready, 1);
    chk("t6_tie_b_ready", b_ready, 0);
    chk("t6_tie_sel", sel, 0);
    drain("t6", 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
